button_event: RTL

Converts the debounced, active-high button level from the debounce stage into single-cycle event pulses: press, release, short click, long press, and optional auto-repeat while held. It sits directly downstream of the debounce stage, in the 27 MHz domain of the Tang Nano 9K design. Its pulses drive counters and control FSMs elsewhere in the design, so every event fires exactly once per physical action.

---
 rtl/button_event_if.sv | 21 ++
 rtl/button_event.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/button_event_if.sv
// Button level in, single-cycle button events out; the event generator
// takes the slave side of this bundle.
interface button_event_if;
  logic btn_s;
  logic press_pulse;
  logic release_pulse;
  logic click_pulse;
  logic long_pulse;
  logic repeat_pulse;
  logic held;

  modport master (
    output btn_s,
    input  press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );

  modport slave (
    input  btn_s,
    output press_pulse, release_pulse, click_pulse, long_pulse, repeat_pulse, held
  );
endinterface

// File: rtl/button_event.sv
// Turns a debounced button level into press/release/click/long/repeat pulses.
// Define AUTO_REPEAT_EN to emit repeat_pulse while the button stays long-held.
module button_event #(
  parameter int LONG_TIME   = 27000000,
  parameter int REPEAT_TIME = 6750000
) (
  input logic         clk,
  input logic         rst,
  button_event_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRESS = 2'd1,
    ST_LONG  = 2'd2
  } state_t;

  localparam logic [24:0] LONG_LAST = 25'(LONG_TIME - 1);

  // Parameter range guard, evaluated at elaboration only
  if (LONG_TIME < 2 || LONG_TIME > 33554431) begin : g_bad_long
    $error("button_event: LONG_TIME out of range 2..2^25-1");
  end
  if (REPEAT_TIME < 2 || REPEAT_TIME > 33554431) begin : g_bad_repeat
    $error("button_event: REPEAT_TIME out of range 2..2^25-1");
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [24:0] REPEAT_LAST = 25'(REPEAT_TIME - 1);
  logic repeat_s;
  logic repeat_r;
`endif

  state_t      state_r;
  state_t      state_nxt_s;
  logic [24:0] cnt_r;
  logic [24:0] cnt_nxt_s;
  logic        press_s;
  logic        release_s;
  logic        click_s;
  logic        long_s;
  logic        held_s;
  logic        press_r;
  logic        release_r;
  logic        click_r;
  logic        long_r;
  logic        held_r;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode; release always wins over the long threshold
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.btn_s) state_nxt_s = ST_PRESS;
        else           state_nxt_s = ST_IDLE;
      end
      ST_PRESS: begin
        if (!bus.btn_s)              state_nxt_s = ST_IDLE;
        else if (cnt_r == LONG_LAST) state_nxt_s = ST_LONG;
        else                         state_nxt_s = ST_PRESS;
      end
      ST_LONG: begin
        if (!bus.btn_s) state_nxt_s = ST_IDLE;
        else            state_nxt_s = ST_LONG;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Pulse and counter decode; counter is cleared at every terminal value
  always_comb begin
    cnt_nxt_s = 25'd0;
    press_s   = 1'b0;
    release_s = 1'b0;
    click_s   = 1'b0;
    long_s    = 1'b0;
`ifdef AUTO_REPEAT_EN
    repeat_s  = 1'b0;
`endif
    case (state_r)
      ST_IDLE: begin
        if (bus.btn_s) press_s = 1'b1;
        else           press_s = 1'b0;
      end
      ST_PRESS: begin
        if (!bus.btn_s) begin
          release_s = 1'b1;
          click_s   = 1'b1;
        end else if (cnt_r == LONG_LAST) begin
          long_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 25'd1;
        end
      end
      ST_LONG: begin
        if (!bus.btn_s) begin
          release_s = 1'b1;
        end
`ifdef AUTO_REPEAT_EN
        else if (cnt_r == REPEAT_LAST) begin
          repeat_s = 1'b1;
        end else begin
          cnt_nxt_s = cnt_r + 25'd1;
        end
`else
        else begin
          cnt_nxt_s = 25'd0;
        end
`endif
      end
      default: cnt_nxt_s = 25'd0;
    endcase
    held_s = (state_nxt_s != ST_IDLE);
  end

  // Counter and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r     <= 25'd0;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      click_r   <= 1'b0;
      long_r    <= 1'b0;
      held_r    <= 1'b0;
`ifdef AUTO_REPEAT_EN
      repeat_r  <= 1'b0;
`endif
    end else begin
      cnt_r     <= cnt_nxt_s;
      press_r   <= press_s;
      release_r <= release_s;
      click_r   <= click_s;
      long_r    <= long_s;
      held_r    <= held_s;
`ifdef AUTO_REPEAT_EN
      repeat_r  <= repeat_s;
`endif
    end
  end

  assign bus.press_pulse   = press_r;
  assign bus.release_pulse = release_r;
  assign bus.click_pulse   = click_r;
  assign bus.long_pulse    = long_r;
  assign bus.held          = held_r;
`ifdef AUTO_REPEAT_EN
  assign bus.repeat_pulse  = repeat_r;
`else
  assign bus.repeat_pulse  = 1'b0;
`endif

endmodule
